// File: rtl/vtg_prog_if.sv
// Configuration and video-output bundle for the programmable timing generator.
// master drives the cfg_* set and observes status and timing outputs.
interface vtg_prog_if #(
    parameter int CW = 12
);
    logic [CW-1:0] cfg_h_active;
    logic [CW-1:0] cfg_h_sync_start;
    logic [CW-1:0] cfg_h_sync_end;
    logic [CW-1:0] cfg_h_total;
    logic [CW-1:0] cfg_v_active;
    logic [CW-1:0] cfg_v_sync_start;
    logic [CW-1:0] cfg_v_sync_end;
    logic [CW-1:0] cfg_v_total;
    logic          cfg_hsync_pol;
    logic          cfg_vsync_pol;
    logic          cfg_valid;
    logic          cfg_pending;
    logic          cfg_error;
    logic [CW-1:0] vtg_hcount;
    logic [CW-1:0] vtg_vcount;
    logic          phy_hsync;
    logic          phy_vsync;
    logic          phy_de;
    logic          frame_start;
    logic          line_start;

    modport master (
        output cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
        output cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total,
        output cfg_hsync_pol, cfg_vsync_pol, cfg_valid,
        input  cfg_pending, cfg_error,
        input  vtg_hcount, vtg_vcount, phy_hsync, phy_vsync, phy_de,
        input  frame_start, line_start
    );

    modport slave (
        input  cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total,
        input  cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total,
        input  cfg_hsync_pol, cfg_vsync_pol, cfg_valid,
        output cfg_pending, cfg_error,
        output vtg_hcount, vtg_vcount, phy_hsync, phy_vsync, phy_de,
        output frame_start, line_start
    );
endinterface

// File: rtl/vtg_prog.sv
// Runtime-programmable video timing generator with a double-buffered timing set
// that is swapped in only where the counters wrap to (0, 0).
module vtg_prog #(
    parameter int CW = 12
) (
    input  logic        clk_dvi,
    input  logic        rst_dvi,
    vtg_prog_if.slave   bus
);
    typedef struct packed {
        logic [CW-1:0] ha, hss, hse, ht;
        logic [CW-1:0] va, vss, vse, vt;
        logic          hp, vp;
    } tset_t;

    localparam tset_t DEF_SET = '{
        ha: CW'(1280), hss: CW'(1390), hse: CW'(1430), ht: CW'(1650),
        va: CW'(720),  vss: CW'(725),  vse: CW'(730),  vt: CW'(750),
        hp: 1'b1, vp: 1'b1
    };
    localparam logic [CW-1:0] RST_H = CW'(1649);
    localparam logic [CW-1:0] RST_V = CW'(749);

    tset_t         act, pend, cfg_in, act_nx;
    logic          pend_vld, err;
    logic          legal, h_last, v_last, wrap;
    logic [CW-1:0] hcount, vcount, h_nx, v_nx;
    logic          de, hs, vs, fs, ls;

    always_comb begin
        cfg_in = '{
            ha: bus.cfg_h_active, hss: bus.cfg_h_sync_start,
            hse: bus.cfg_h_sync_end, ht: bus.cfg_h_total,
            va: bus.cfg_v_active, vss: bus.cfg_v_sync_start,
            vse: bus.cfg_v_sync_end, vt: bus.cfg_v_total,
            hp: bus.cfg_hsync_pol, vp: bus.cfg_vsync_pol
        };
        // total >= 2 guards the total-1 term against underflow
        legal = (cfg_in.ht >= CW'(2)) && (cfg_in.vt >= CW'(2)) &&
                (cfg_in.ha != '0) && (cfg_in.ha <= cfg_in.hss) &&
                (cfg_in.hss < cfg_in.hse) && (cfg_in.hse <= cfg_in.ht - CW'(1)) &&
                (cfg_in.va != '0) && (cfg_in.va <= cfg_in.vss) &&
                (cfg_in.vss < cfg_in.vse) && (cfg_in.vse <= cfg_in.vt - CW'(1));

        h_last = (hcount == act.ht - CW'(1));
        v_last = (vcount == act.vt - CW'(1));
        wrap   = h_last && v_last;
        h_nx   = h_last ? '0 : hcount + CW'(1);
        v_nx   = h_last ? (v_last ? '0 : vcount + CW'(1)) : vcount;
        // outputs at the new (0, 0) must already reflect the swapped-in set
        act_nx = (wrap && pend_vld) ? pend : act;
    end

    always_ff @(posedge clk_dvi or posedge rst_dvi) begin
        if (rst_dvi) begin
            act      <= DEF_SET;
            pend     <= DEF_SET;
            pend_vld <= 1'b0;
            err      <= 1'b0;
            hcount   <= RST_H;
            vcount   <= RST_V;
            de       <= 1'b0;
            hs       <= 1'b0;
            vs       <= 1'b0;
            fs       <= 1'b0;
            ls       <= 1'b0;
        end else begin
            act <= act_nx;
            // a capture on the apply edge wins over the clear
            if (bus.cfg_valid && legal) begin
                pend     <= cfg_in;
                pend_vld <= 1'b1;
            end else if (wrap) begin
                pend_vld <= 1'b0;
            end
            err    <= bus.cfg_valid && !legal;
            hcount <= h_nx;
            vcount <= v_nx;
            de     <= (h_nx < act_nx.ha) && (v_nx < act_nx.va);
            hs     <= act_nx.hp ~^ ((h_nx >= act_nx.hss) && (h_nx < act_nx.hse));
            vs     <= act_nx.vp ~^ ((v_nx >= act_nx.vss) && (v_nx < act_nx.vse));
            fs     <= (h_nx == '0) && (v_nx == '0);
            ls     <= (h_nx == '0);
        end
    end

    assign bus.cfg_pending = pend_vld;
    assign bus.cfg_error   = err;
    assign bus.vtg_hcount  = hcount;
    assign bus.vtg_vcount  = vcount;
    assign bus.phy_de      = de;
    assign bus.phy_hsync   = hs;
    assign bus.phy_vsync   = vs;
    assign bus.frame_start = fs;
    assign bus.line_start  = ls;
endmodule

// File: tb/tb_vtg_prog.sv
// Directed bench for vtg_prog: one full 720p frame, mode changes, rejects,
// simultaneous apply/capture and mid-line reset.
`timescale 1ns/1ps
module tb_vtg_prog;
    typedef struct {
        int ha, hss, hse, ht, va, vss, vse, vt;
        bit hp, vp;
    } tset_t;

    logic clk_dvi = 1'b0;
    logic rst_dvi = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    vtg_prog_if #(.CW(12)) bus ();
    vtg_prog #(.CW(12)) dut (.clk_dvi(clk_dvi), .rst_dvi(rst_dvi), .bus(bus));

    always #5 clk_dvi = ~clk_dvi;

    localparam tset_t S_DEF = '{1280, 1390, 1430, 1650, 720, 725, 730, 750, 1'b1, 1'b1};
    localparam tset_t S_A   = '{4, 5, 6, 8, 2, 3, 4, 5, 1'b0, 1'b0};
    localparam tset_t S_B1  = '{4, 5, 6, 8, 2, 3, 4, 5, 1'b1, 1'b1};
    localparam tset_t S_B2  = '{4, 5, 6, 10, 2, 3, 4, 5, 1'b0, 1'b0};
    localparam tset_t S_C   = '{3, 4, 5, 6, 2, 3, 4, 5, 1'b1, 1'b1};
    localparam tset_t S_D   = '{2, 4, 5, 7, 1, 2, 3, 4, 1'b1, 1'b0};
    localparam tset_t S_BAD = '{4, 3, 6, 8, 2, 3, 4, 5, 1'b0, 1'b0};
    localparam tset_t S_BAD0 = '{0, 3, 6, 8, 2, 3, 4, 5, 1'b0, 1'b0};
    localparam tset_t S_BADT = '{4, 5, 8, 8, 2, 3, 4, 5, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input tset_t s);
        bus.cfg_h_active     = 12'(s.ha);
        bus.cfg_h_sync_start = 12'(s.hss);
        bus.cfg_h_sync_end   = 12'(s.hse);
        bus.cfg_h_total      = 12'(s.ht);
        bus.cfg_v_active     = 12'(s.va);
        bus.cfg_v_sync_start = 12'(s.vss);
        bus.cfg_v_sync_end   = 12'(s.vse);
        bus.cfg_v_total      = 12'(s.vt);
        bus.cfg_hsync_pol    = s.hp;
        bus.cfg_vsync_pol    = s.vp;
        bus.cfg_valid        = 1'b1;
    endtask

    // Check n samples from frame position j0 under set s, stepping one clock each.
    task automatic run(input string tag, input tset_t s, input int j0, input int n);
        for (int j = j0; j < j0 + n; j++) begin
            int h;
            int v;
            logic e_de, e_hs, e_vs;
            logic [28:0] got, exp;
            h    = j % s.ht;
            v    = (j / s.ht) % s.vt;
            e_de = (h < s.ha) && (v < s.va);
            e_hs = s.hp ? (h >= s.hss && h < s.hse) : !(h >= s.hss && h < s.hse);
            e_vs = s.vp ? (v >= s.vss && v < s.vse) : !(v >= s.vss && v < s.vse);
            exp  = {12'(h), 12'(v), e_de, e_hs, e_vs, (h == 0 && v == 0), (h == 0)};
            got  = {bus.vtg_hcount, bus.vtg_vcount, bus.phy_de, bus.phy_hsync,
                    bus.phy_vsync, bus.frame_start, bus.line_start};
            chk(tag, 64'(got), 64'(exp));
            @(posedge clk_dvi);
            #1;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, 64'({bus.vtg_hcount, bus.vtg_vcount, bus.phy_de, bus.phy_hsync,
                      bus.phy_vsync, bus.frame_start, bus.line_start}),
            64'({12'd1649, 12'd749, 5'b00000}));
        chk({tag, "_st"}, 64'({bus.cfg_pending, bus.cfg_error}), 64'(0));
    endtask

    initial begin
        #30_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

    initial begin
        drive(S_DEF);
        bus.cfg_valid = 1'b0;
        #12;
        chk_reset("rst");
        rst_dvi = 1'b0;
        @(posedge clk_dvi);
        #1;

        // full default frame with a reject and a capture mid-frame
        run("f720", S_DEF, 0, 500);
        drive(S_BAD);
        run("f720", S_DEF, 500, 1);
        bus.cfg_valid = 1'b0;
        chk("bad_err", 64'(bus.cfg_error), 64'(1));
        chk("bad_pend", 64'(bus.cfg_pending), 64'(0));
        run("f720", S_DEF, 501, 1);
        chk("bad_err_off", 64'(bus.cfg_error), 64'(0));
        drive(S_A);
        run("f720", S_DEF, 502, 1);
        bus.cfg_valid = 1'b0;
        chk("a_pend", 64'(bus.cfg_pending), 64'(1));
        chk("a_err", 64'(bus.cfg_error), 64'(0));
        run("f720", S_DEF, 503, 1650 * 750 - 503);

        // A applied at the wrap; two captures, last writer wins
        chk("a_applied", 64'(bus.cfg_pending), 64'(0));
        run("fA", S_A, 0, 10);
        drive(S_B1);
        run("fA", S_A, 10, 1);
        drive(S_B2);
        run("fA", S_A, 11, 1);
        bus.cfg_valid = 1'b0;
        chk("b_pend", 64'(bus.cfg_pending), 64'(1));
        run("fA", S_A, 12, 28);
        chk("b_applied", 64'(bus.cfg_pending), 64'(0));

        // C pending, D offered exactly on the wrap edge
        run("fB", S_B2, 0, 5);
        drive(S_C);
        run("fB", S_B2, 5, 1);
        bus.cfg_valid = 1'b0;
        run("fB", S_B2, 6, 43);
        drive(S_D);
        run("fB", S_B2, 49, 1);
        bus.cfg_valid = 1'b0;
        chk("d_pend_at_wrap", 64'(bus.cfg_pending), 64'(1));
        run("fC", S_C, 0, 30);
        chk("d_applied", 64'(bus.cfg_pending), 64'(0));

        // boundary rejects: zero active, sync_end == total
        run("fD", S_D, 0, 3);
        drive(S_BAD0);
        run("fD", S_D, 3, 1);
        chk("bad0_err", 64'(bus.cfg_error), 64'(1));
        drive(S_BADT);
        run("fD", S_D, 4, 1);
        bus.cfg_valid = 1'b0;
        chk("badt_err", 64'(bus.cfg_error), 64'(1));
        run("fD", S_D, 5, 1);
        chk("badt_err_off", 64'(bus.cfg_error), 64'(0));
        chk("badt_pend", 64'(bus.cfg_pending), 64'(0));
        run("fD", S_D, 6, 22);
        run("fD2", S_D, 0, 28);

        // asynchronous reset mid-line with a set pending
        drive(S_A);
        run("fD3", S_D, 0, 1);
        bus.cfg_valid = 1'b0;
        chk("r_pend", 64'(bus.cfg_pending), 64'(1));
        #2;
        rst_dvi = 1'b1;
        #1;
        chk_reset("rst_mid");
        #2;
        rst_dvi = 1'b0;
        @(posedge clk_dvi);
        #1;
        run("post_rst", S_DEF, 0, 1650);
        chk("post_rst_pend", 64'(bus.cfg_pending), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
